ddr3_port_scheduler: RTL and testbench

Sequential scheduler for the DDR3 interface. It shares the single DDR3 read/write engine among four frame-buffer ports: HDMI read, camera write and two auxiliary ports. The fixed high-index-first priority is extended with grant locking for a whole burst, starvation aging, a burst timeout and a one-cycle turnaround gap. It sits between the port FIFOs' burst requests and the DDR3 engine's start/done handshake.

---
 rtl/ddr_arb_pkg.sv | 18 +
 rtl/ddr3_port_scheduler_if.sv | 24 ++
 rtl/ddr_prio_pick.sv | 20 ++
 rtl/ddr3_port_scheduler.sv | 132 +++++++++++++
 tb/tb_ddr3_port_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared constants and FSM encoding for the DDR3 port scheduler.
package ddr_arb_pkg;

  localparam int unsigned NUM_PORTS = 4;

  // Port indices; a higher index means a higher static priority.
  localparam int unsigned HDMI   = 3;
  localparam int unsigned CAMERA = 2;
  localparam int unsigned AUX1   = 1;
  localparam int unsigned AUX0   = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StGap  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ddr3_port_scheduler_if.sv
// Burst request / grant bundle between the port FIFOs, the DDR3 engine and the scheduler.
interface ddr3_port_scheduler_if;
  import ddr_arb_pkg::*;

  logic [NUM_PORTS-1:0] request;
  logic                 xfer_done;
  logic [NUM_PORTS-1:0] grant;
  logic                 xfer_start;
  logic [NUM_PORTS-1:0] starving;
  logic                 timeout_err;

  // Requester / engine side.
  modport master (
    output request, xfer_done,
    input  grant, xfer_start, starving, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  request, xfer_done,
    output grant, xfer_start, starving, timeout_err
  );

endinterface

// File: rtl/ddr_prio_pick.sv
// Highest-index-first one-hot picker, purely combinational.
module ddr_prio_pick
  import ddr_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] onehot
);

  // Scan upward so the highest set bit is the last one kept.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_port_scheduler.sv
// Shares one DDR3 read/write engine among four frame-buffer ports with burst-long grant
// locking, starvation aging, a burst timeout and a one-cycle turnaround gap.
module ddr3_port_scheduler
  import ddr_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned TIMEOUT      = 1024
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  ddr3_port_scheduler_if.slave bus
);

  localparam int unsigned AgeWidth  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BusyWidth = $clog2(TIMEOUT);
  localparam logic [AgeWidth-1:0]  AgeLimit = AgeWidth'(STARVE_LIMIT);
  localparam logic [BusyWidth-1:0] BusyLast = BusyWidth'(TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 xfer_start_q, xfer_start_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [BusyWidth-1:0] busy_cnt_q, busy_cnt_d;
  logic [AgeWidth-1:0]  age_q [NUM_PORTS];
  logic [AgeWidth-1:0]  age_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] starving;
  logic [NUM_PORTS-1:0] pick_req;
  logic [NUM_PORTS-1:0] pick_starve;
  logic [NUM_PORTS-1:0] winner;

  ddr_prio_pick u_pick_req (
    .req    (bus.request),
    .onehot (pick_req)
  );

  ddr_prio_pick u_pick_starve (
    .req    (starving),
    .onehot (pick_starve)
  );

  // A starving port overrides static priority.
  assign winner = (|pick_starve) ? pick_starve : pick_req;

  // Starving flags come straight from the saturated aging registers.
  always_comb begin
    starving = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      starving[i] = (age_q[i] == AgeLimit);
    end
  end

  // Aging: count cycles a port waits while requesting, saturating at the limit.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      age_d[i] = age_q[i];
      if (!bus.request[i] || grant_q[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != AgeLimit) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // Arbitration FSM next-state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    xfer_start_d  = 1'b0;
    timeout_err_d = 1'b0;
    busy_cnt_d    = busy_cnt_q;
    unique case (state_q)
      StIdle, StGap: begin
        if (|bus.request) begin
          grant_d      = winner;
          xfer_start_d = 1'b1;
          busy_cnt_d   = '0;
          state_d      = StBusy;
        end else begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      StBusy: begin
        // Done takes precedence over a coincident timeout.
        if (bus.xfer_done) begin
          grant_d = '0;
          state_d = StGap;
        end else if (busy_cnt_q == BusyLast) begin
          grant_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = StGap;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      xfer_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_cnt_q    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      xfer_start_q  <= xfer_start_d;
      timeout_err_q <= timeout_err_d;
      busy_cnt_q    <= busy_cnt_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.xfer_start  = xfer_start_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.starving    = starving;

endmodule

// File: tb/tb_ddr3_port_scheduler.sv
// Self-checking bench for ddr3_port_scheduler: vector table, corner sequences and a
// randomized run against a cycle-level reference model.
module tb_ddr3_port_scheduler;
  import ddr_arb_pkg::*;

  localparam int unsigned StarveLimit = 8;
  localparam int unsigned Timeout     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  ddr3_port_scheduler_if bus ();

  ddr3_port_scheduler #(
    .STARVE_LIMIT (StarveLimit),
    .TIMEOUT      (Timeout)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
    logic       exp_start;
    logic       exp_terr;
  } vec_t;

  vec_t vecs [12];

  // Reference model: tracks who holds the engine, how long, and how long each port waited.
  logic [3:0] m_grant;
  logic       m_start;
  logic       m_terr;
  logic [3:0] m_starving;
  bit         m_busy;
  int         m_elapsed;
  int         m_age [4];

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_grant    = '0;
    m_start    = 1'b0;
    m_terr     = 1'b0;
    m_starving = '0;
    m_busy     = 1'b0;
    m_elapsed  = 0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic done);
    logic [3:0] starv;
    int         w;
    w = -1;
    for (int i = 0; i < 4; i++) starv[i] = (m_age[i] == int'(StarveLimit));
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || m_grant[i]) m_age[i] = 0;
      else if (m_age[i] < int'(StarveLimit)) m_age[i] = m_age[i] + 1;
    end
    m_start = 1'b0;
    m_terr  = 1'b0;
    if (m_busy) begin
      if (done) begin
        m_busy  = 1'b0;
        m_grant = '0;
      end else if (m_elapsed == int'(Timeout) - 1) begin
        m_busy  = 1'b0;
        m_grant = '0;
        m_terr  = 1'b1;
      end else begin
        m_elapsed++;
      end
    end else if (req != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (starv[i]) w = i;
      if (w < 0) for (int i = 0; i < 4; i++) if (req[i]) w = i;
      m_grant   = 4'b0001 << w;
      m_start   = 1'b1;
      m_busy    = 1'b1;
      m_elapsed = 0;
    end else begin
      m_grant = '0;
    end
    for (int i = 0; i < 4; i++) m_starving[i] = (m_age[i] == int'(StarveLimit));
  endfunction

  task automatic do_reset();
    bus.request   = '0;
    bus.xfer_done = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          seen_starve;
    bit          seen_win;
    int          since;
    int unsigned done_div;
    logic [3:0]  r;
    logic        d;

    // Priority, gap, lock and done-in-idle vectors, applied from IDLE.
    vecs[0]  = '{4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0};
    vecs[1]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 1'b0};
    vecs[2]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    // Reset and idle.
    do_reset();
    #1;
    check4("rst_grant", bus.grant, 4'b0000);
    check1("rst_start", bus.xfer_start, 1'b0);
    check1("rst_terr", bus.timeout_err, 1'b0);
    check4("rst_starving", bus.starving, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      step();
      check4("idle_grant", bus.grant, 4'b0000);
      check1("idle_start", bus.xfer_start, 1'b0);
    end

    // Vector table.
    for (int k = 0; k < 12; k++) begin
      bus.request   = vecs[k].req;
      bus.xfer_done = vecs[k].done;
      step();
      check4($sformatf("tbl%0d_grant", k), bus.grant, vecs[k].exp_grant);
      check1($sformatf("tbl%0d_start", k), bus.xfer_start, vecs[k].exp_start);
      check1($sformatf("tbl%0d_terr", k), bus.timeout_err, vecs[k].exp_terr);
      check4($sformatf("tbl%0d_starving", k), bus.starving, 4'b0000);
    end

    // Timeout without done: grant drops exactly Timeout cycles after it appears.
    bus.request   = 4'b0100;
    bus.xfer_done = 1'b0;
    step();
    check4("to_first_grant", bus.grant, 4'b0100);
    check1("to_first_start", bus.xfer_start, 1'b1);
    for (int c = 1; c < int'(Timeout); c++) begin
      step();
      check4("to_hold_grant", bus.grant, 4'b0100);
      check1("to_hold_terr", bus.timeout_err, 1'b0);
    end
    step();
    check4("to_drop_grant", bus.grant, 4'b0000);
    check1("to_drop_terr", bus.timeout_err, 1'b1);
    step();
    check1("to_pulse_once", bus.timeout_err, 1'b0);
    check4("to_regrant", bus.grant, 4'b0100);
    check1("to_regrant_start", bus.xfer_start, 1'b1);

    // Done coinciding with the timeout cycle counts as done only.
    for (int c = 1; c < int'(Timeout); c++) step();
    check4("to2_still_granted", bus.grant, 4'b0100);
    bus.xfer_done = 1'b1;
    step();
    check4("to2_drop_grant", bus.grant, 4'b0000);
    check1("to2_no_terr", bus.timeout_err, 1'b0);
    bus.xfer_done = 1'b0;
    bus.request   = 4'b0000;
    step();
    check1("to2_after_terr", bus.timeout_err, 1'b0);
    check4("to2_idle", bus.grant, 4'b0000);

    // Aging: port 0 eventually wins over a continuously requesting port 3.
    seen_starve   = 1'b0;
    seen_win      = 1'b0;
    since         = 0;
    bus.request   = 4'b1001;
    for (int c = 0; c < 200 && !seen_win; c++) begin
      step();
      bus.xfer_done = 1'b0;
      if (bus.xfer_start) begin
        since = 0;
        if (seen_starve) begin
          check4("aging_winner", bus.grant, 4'b0001);
          seen_win = 1'b1;
        end
      end else if (bus.grant != 4'b0000) begin
        since++;
      end
      if (bus.starving[0]) seen_starve = 1'b1;
      if (bus.grant != 4'b0000 && since == 4) bus.xfer_done = 1'b1;
    end
    check1("aging_starve_seen", seen_starve, 1'b1);
    check1("aging_win_seen", seen_win, 1'b1);

    // Asynchronous reset in the middle of a burst.
    bus.xfer_done = 1'b0;
    step();
    check4("rmb_busy_grant", bus.grant, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check4("rmb_async_grant", bus.grant, 4'b0000);
    check4("rmb_starving", bus.starving, 4'b0000);
    check1("rmb_start", bus.xfer_start, 1'b0);
    bus.request = 4'b0000;
    @(negedge clk);
    rst_n       = 1'b1;
    bus.request = 4'b1001;
    step();
    check4("rmb_restart_grant", bus.grant, 4'b1000);
    check1("rmb_restart_start", bus.xfer_start, 1'b1);
    check4("rmb_restart_starving", bus.starving, 4'b0000);

    // Randomized run against the reference model.
    do_reset();
    r        = '0;
    done_div = 2;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        unique case ((c / 150) % 3)
          0:       done_div = 2;
          1:       done_div = 8;
          default: done_div = 40;
        endcase
      end
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d             = ($urandom_range(0, done_div - 1) == 0);
      bus.request   = r;
      bus.xfer_done = d;
      step();
      model_step(r, d);
      check4("rnd_grant", bus.grant, m_grant);
      check1("rnd_start", bus.xfer_start, m_start);
      check1("rnd_terr", bus.timeout_err, m_terr);
      check4("rnd_starving", bus.starving, m_starving);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
